lock_seq_ctrl: RTL and testbench
================================

Name: lock_seq_ctrl

Overview:
- Master sequencer for the digital lock. Collects debounced keypad digits, compares the entered code against a stored code, and manages the failed-attempt count, timed lockout, auto-relock and code reprogramming.
- Drives the enb_lock / disable_cnt controls consumed by the hold/unlock counter blocks, plus status outputs for LEDs and the 7-segment driver.
- Inputs are single-cycle pulses from upstream button_push debouncers and edge detectors in the clk_in domain.

Parameters:
NUM_DIGITS, 4, code length in digits (2..8)
DIGIT_W, 4, bits per digit
DEFAULT_CODE, 16'h1234, code loaded at reset (NUM_DIGITS*DIGIT_W bits, digit 0 in MSBs)
MAX_FAIL, 3, consecutive failures that trigger lockout (>=1)
LOCKOUT_CYC, 100000000, lockout duration in clk_in cycles
ENTRY_TO, 500000000, idle cycles in ENTRY/PROGRAM before abandoning entry
RELOCK_CYC, 1000000000, idle cycles in UNLOCKED before auto-relock

Ports:
clk_in  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
digit_valid  in  1  one-cycle pulse, digit_in valid
digit_in  in  DIGIT_W  keypad digit
enter_pulse  in  1  one-cycle pulse, submit entry / manual lock
clear_pulse  in  1  one-cycle pulse, abandon current entry
set_code_pulse  in  1  one-cycle pulse, begin reprogramming (UNLOCKED only)
locked  out  1  high in every state except UNLOCKED and PROGRAM
unlocked  out  1  high in UNLOCKED and PROGRAM
enb_lock  out  1  high in UNLOCKED only; enables hold counter
disable_cnt  out  1  high in LOCKOUT and PROGRAM
alarm  out  1  high in LOCKOUT
ok_pulse  out  1  one cycle on successful compare
err_pulse  out  1  one cycle on failed compare or short entry
digit_idx  out  4  digits captured so far (0..NUM_DIGITS)
fail_cnt  out  4  consecutive failures, saturates at MAX_FAIL

Behaviour:
- Reset (async, immediate) sets the following. State LOCKED. code_reg = DEFAULT_CODE. Entry buffer = 0. digit_idx = 0. fail_cnt = 0. All timers = 0. locked = 1; unlocked, enb_lock, disable_cnt, alarm, ok_pulse and err_pulse = 0. Reset asserted mid-lockout or mid-entry aborts that operation; it does not restore a previously programmed code.
- All outputs are registered. Status outputs are decoded from the registered state.
- Same-cycle priority: clear_pulse > enter_pulse > set_code_pulse > digit_valid. Lower-priority pulses in that cycle are dropped.
- LOCKED:
  - digit_valid: store the digit in slot 0, digit_idx = 1, go to ENTRY.
  - enter_pulse and clear_pulse are ignored.
- ENTRY:
  - digit_valid with digit_idx < NUM_DIGITS: store the digit at slot digit_idx, increment digit_idx, reset the idle timer.
  - Digits arriving when digit_idx == NUM_DIGITS are ignored and do not reset the timer.
  - clear_pulse: buffer = 0, digit_idx = 0, go to LOCKED. Not counted as a failure.
  - Idle timer reaching ENTRY_TO: same action as clear.
  - enter_pulse with digit_idx == NUM_DIGITS: go to CHECK.
  - enter_pulse with digit_idx < NUM_DIGITS: counts as a failure and takes the CHECK-fail path directly (err_pulse on the next edge).
- CHECK (exactly one cycle):
  - buffer == code_reg: ok_pulse, fail_cnt = 0, go to UNLOCKED.
  - Mismatch: err_pulse, fail_cnt + 1. If that reaches MAX_FAIL, go to LOCKOUT and load the timer with LOCKOUT_CYC-1; otherwise go to LOCKED.
  - Buffer and digit_idx are cleared on exit.
  - Latency: enter_pulse at edge N gives the outcome state and ok/err pulse at edge N+2.
- LOCKOUT:
  - All input pulses are ignored.
  - Timer decrements each cycle. At 0, go to LOCKED, fail_cnt = 0, alarm drops. Total duration is exactly LOCKOUT_CYC cycles.
- UNLOCKED:
  - enter_pulse: go to LOCKED (manual lock).
  - set_code_pulse: go to PROGRAM with digit_idx = 0.
  - Idle RELOCK_CYC cycles with no input pulse: go to LOCKED.
  - Any input pulse restarts the relock timer.
- PROGRAM:
  - Digits are captured as in ENTRY.
  - enter_pulse with digit_idx == NUM_DIGITS: code_reg = buffer, ok_pulse, go to UNLOCKED.
  - Short enter, clear_pulse or ENTRY_TO timeout: code_reg unchanged, err_pulse only on the short enter, go to UNLOCKED.
- Counters:
  - Timers are sized from $clog2 of the largest timing parameter.
  - fail_cnt never exceeds MAX_FAIL. digit_idx never exceeds NUM_DIGITS.
  - No wrap-around is permitted.

Test Plan:
Use DEFAULT_CODE=16'h1234, MAX_FAIL=3, LOCKOUT_CYC=20, ENTRY_TO=30, RELOCK_CYC=50.
- Reset: assert rst mid-cycle -> locked=1, enb_lock=0, fail_cnt=0, digit_idx=0 immediately, without waiting for a clock edge.
- Correct code: digits 1,2,3,4 then enter -> ok_pulse 2 edges after enter, unlocked=1, enb_lock=1, fail_cnt=0. 50 idle cycles later -> locked=1.
- Three failures: enter 1,2,3,5 three times -> err_pulse each time, fail_cnt 1, 2, 3; after the third, alarm=1 and disable_cnt=1. Digit and enter pulses during lockout are ignored. Exactly 20 cycles later -> alarm=0, locked=1, fail_cnt=0.
- Boundary entry cases:
  - 1, 2, enter -> err_pulse, fail_cnt=1.
  - 1,2,3,4,9, enter -> unlocks (fifth digit dropped).
  - 1,2 then 30 idle cycles -> LOCKED, digit_idx=0, fail_cnt unchanged.
- Priority: clear_pulse and enter_pulse in the same cycle with 4 digits entered -> entry abandoned, no ok/err pulse, fail_cnt unchanged.
- Reprogram: unlock, set_code_pulse, then 9,8,7,6, enter -> ok_pulse. Manual lock. Entering 1,2,3,4 now fails; 9,8,7,6 unlocks. Asserting rst restores 1,2,3,4.

Source files
------------

// File: rtl/lock_seq_ctrl.sv
// lock_seq_ctrl: digital lock master sequencer (code entry, compare, lockout, auto-relock, reprogram)
// Ports: clk_in/rst clock and async reset; digit_valid/digit_in, enter_pulse, clear_pulse, set_code_pulse
// keypad pulses; locked/unlocked/enb_lock/disable_cnt/alarm status; ok_pulse/err_pulse compare strobes;
// digit_idx digits captured; fail_cnt consecutive failures.
module lock_seq_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W = 4,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
    parameter int MAX_FAIL = 3,
    parameter int LOCKOUT_CYC = 100000000,
    parameter int ENTRY_TO = 500000000,
    parameter int RELOCK_CYC = 1000000000
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               enter_pulse,
    input  logic               clear_pulse,
    input  logic               set_code_pulse,
    output logic               locked,
    output logic               unlocked,
    output logic               enb_lock,
    output logic               disable_cnt,
    output logic               alarm,
    output logic               ok_pulse,
    output logic               err_pulse,
    output logic [3:0]         digit_idx,
    output logic [3:0]         fail_cnt
);
    localparam int CW = NUM_DIGITS * DIGIT_W;
    localparam int T_A = (LOCKOUT_CYC > ENTRY_TO) ? LOCKOUT_CYC : ENTRY_TO;
    localparam int T_MAX = (T_A > RELOCK_CYC) ? T_A : RELOCK_CYC;
    localparam int TW = $clog2(T_MAX + 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCKOUT_CYC - 1);
    localparam logic [TW-1:0] ENTRY_LAST = TW'(ENTRY_TO - 1);
    localparam logic [TW-1:0] RELOCK_LAST = TW'(RELOCK_CYC - 1);
    localparam logic [3:0] N_DIG = 4'(NUM_DIGITS);
    localparam logic [3:0] N_FAIL = 4'(MAX_FAIL);

    typedef enum logic [2:0] {S_LOCKED, S_ENTRY, S_CHECK, S_LOCKOUT, S_UNLOCKED, S_PROGRAM} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] code_q, code_d, buf_q, buf_d, buf_sh;
    logic [3:0]    idx_q, idx_d, fail_q, fail_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ok_q, ok_d, err_q, err_d;
    logic          locked_q, locked_d, unlocked_q, unlocked_d, enb_q, enb_d;
    logic          dis_q, dis_d, alarm_q, alarm_d;
    logic          clr, ent, setc, dig, any_in, full, fail_ev;

    // Resolve same-cycle pulses by priority: clear > enter > set_code > digit.
    assign clr    = clear_pulse;
    assign ent    = enter_pulse & ~clear_pulse;
    assign setc   = set_code_pulse & ~clear_pulse & ~enter_pulse;
    assign dig    = digit_valid & ~clear_pulse & ~enter_pulse & ~set_code_pulse;
    assign any_in = digit_valid | enter_pulse | clear_pulse | set_code_pulse;
    assign full   = idx_q == N_DIG;
    // Shifting digits in leaves digit 0 in the MSBs once the buffer is full.
    assign buf_sh = {buf_q[CW-DIGIT_W-1:0], digit_in};

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        fail_ev = 1'b0;
        case (state_q)
            S_LOCKED: begin
                timer_d = '0;
                if (dig) begin
                    buf_d   = buf_sh;
                    idx_d   = 4'd1;
                    state_d = S_ENTRY;
                end
            end
            S_ENTRY, S_PROGRAM: begin
                timer_d = timer_q + TW'(1);
                if (clr || (!ent && !(dig && !full) && timer_q == ENTRY_LAST)) begin
                    buf_d   = '0;
                    idx_d   = '0;
                    timer_d = '0;
                    state_d = (state_q == S_ENTRY) ? S_LOCKED : S_UNLOCKED;
                end else if (ent && state_q == S_PROGRAM) begin
                    code_d  = full ? buf_q : code_q;
                    ok_d    = full;
                    err_d   = !full;
                    buf_d   = '0;
                    idx_d   = '0;
                    timer_d = '0;
                    state_d = S_UNLOCKED;
                end else if (ent) begin
                    state_d = full ? S_CHECK : state_q;
                    fail_ev = !full;
                end else if (dig && !full) begin
                    buf_d   = buf_sh;
                    idx_d   = idx_q + 4'd1;
                    timer_d = '0;
                end
            end
            S_CHECK: begin
                buf_d = '0;
                idx_d = '0;
                if (buf_q == code_q) begin
                    ok_d    = 1'b1;
                    fail_d  = '0;
                    timer_d = '0;
                    state_d = S_UNLOCKED;
                end else begin
                    fail_ev = 1'b1;
                end
            end
            S_LOCKOUT: begin
                timer_d = timer_q - TW'(1);
                if (timer_q == '0) begin
                    timer_d = '0;
                    fail_d  = '0;
                    state_d = S_LOCKED;
                end
            end
            S_UNLOCKED: begin
                timer_d = any_in ? '0 : timer_q + TW'(1);
                if (ent) begin
                    state_d = S_LOCKED;
                end else if (setc) begin
                    buf_d   = '0;
                    idx_d   = '0;
                    state_d = S_PROGRAM;
                end else if (!any_in && timer_q == RELOCK_LAST) begin
                    timer_d = '0;
                    state_d = S_LOCKED;
                end
            end
            default: state_d = S_LOCKED;
        endcase
        // Shared failure path for a mismatching compare and a short entry.
        if (fail_ev) begin
            err_d   = 1'b1;
            buf_d   = '0;
            idx_d   = '0;
            fail_d  = (fail_q >= N_FAIL - 4'd1) ? N_FAIL : fail_q + 4'd1;
            state_d = (fail_q >= N_FAIL - 4'd1) ? S_LOCKOUT : S_LOCKED;
            timer_d = (fail_q >= N_FAIL - 4'd1) ? LOCK_LAST : '0;
        end
        locked_d   = !(state_d == S_UNLOCKED || state_d == S_PROGRAM);
        unlocked_d = state_d == S_UNLOCKED || state_d == S_PROGRAM;
        enb_d      = state_d == S_UNLOCKED;
        dis_d      = state_d == S_LOCKOUT || state_d == S_PROGRAM;
        alarm_d    = state_d == S_LOCKOUT;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= S_LOCKED;
            code_q     <= DEFAULT_CODE;
            buf_q      <= '0;
            idx_q      <= '0;
            fail_q     <= '0;
            timer_q    <= '0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            locked_q   <= 1'b1;
            unlocked_q <= 1'b0;
            enb_q      <= 1'b0;
            dis_q      <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            buf_q      <= buf_d;
            idx_q      <= idx_d;
            fail_q     <= fail_d;
            timer_q    <= timer_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            locked_q   <= locked_d;
            unlocked_q <= unlocked_d;
            enb_q      <= enb_d;
            dis_q      <= dis_d;
            alarm_q    <= alarm_d;
        end
    end

    assign locked      = locked_q;
    assign unlocked    = unlocked_q;
    assign enb_lock    = enb_q;
    assign disable_cnt = dis_q;
    assign alarm       = alarm_q;
    assign ok_pulse    = ok_q;
    assign err_pulse   = err_q;
    assign digit_idx   = idx_q;
    assign fail_cnt    = fail_q;
endmodule

// File: tb/tb_lock_seq_ctrl.sv
// tb_lock_seq_ctrl: scenario and randomized checks of lock_seq_ctrl against a behavioural model
module tb_lock_seq_ctrl;
    localparam int ND = 4;
    localparam int MAXF = 3;
    localparam int LOCK_C = 20;
    localparam int ENT_TO = 30;
    localparam int REL_C = 50;
    localparam int L_LOCKED = 0, L_ENTRY = 1, L_CHECK = 2, L_LOCKOUT = 3, L_UNL = 4, L_PROG = 5;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       digit_valid = 1'b0;
    logic [3:0] digit_in = 4'd0;
    logic       enter_pulse = 1'b0;
    logic       clear_pulse = 1'b0;
    logic       set_code_pulse = 1'b0;
    logic       locked, unlocked, enb_lock, disable_cnt, alarm, ok_pulse, err_pulse;
    logic [3:0] digit_idx, fail_cnt;

    int checks = 0;
    int passes = 0;

    int m_st;
    int m_entry[$];
    int m_code[ND];
    int m_fail, m_idle, m_left;
    bit m_ok, m_err;

    always #5 clk_in = ~clk_in;

    lock_seq_ctrl #(
        .NUM_DIGITS(ND), .DIGIT_W(4), .DEFAULT_CODE(16'h1234), .MAX_FAIL(MAXF),
        .LOCKOUT_CYC(LOCK_C), .ENTRY_TO(ENT_TO), .RELOCK_CYC(REL_C)
    ) dut (
        .clk_in(clk_in), .rst(rst), .digit_valid(digit_valid), .digit_in(digit_in),
        .enter_pulse(enter_pulse), .clear_pulse(clear_pulse), .set_code_pulse(set_code_pulse),
        .locked(locked), .unlocked(unlocked), .enb_lock(enb_lock), .disable_cnt(disable_cnt),
        .alarm(alarm), .ok_pulse(ok_pulse), .err_pulse(err_pulse),
        .digit_idx(digit_idx), .fail_cnt(fail_cnt)
    );

    task automatic model_reset();
        m_st = L_LOCKED;
        m_entry.delete();
        for (int i = 0; i < ND; i++) m_code[i] = i + 1;
        m_fail = 0;
        m_idle = 0;
        m_left = 0;
        m_ok = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_fail();
        m_err = 1'b1;
        m_entry.delete();
        if (m_fail < MAXF) m_fail++;
        if (m_fail == MAXF) begin
            m_st = L_LOCKOUT;
            m_left = LOCK_C;
        end else m_st = L_LOCKED;
    endtask

    task automatic model_leave();
        m_entry.delete();
        m_idle = 0;
        m_st = (m_st == L_ENTRY) ? L_LOCKED : L_UNL;
    endtask

    task automatic model_step(input bit dv, input int d, input bit en, input bit cl, input bit sc);
        bit any_p;
        bit match;
        any_p = dv | en | cl | sc;
        m_ok = 1'b0;
        m_err = 1'b0;
        if (cl) begin en = 0; sc = 0; dv = 0; end
        else if (en) begin sc = 0; dv = 0; end
        else if (sc) dv = 0;
        case (m_st)
            L_LOCKED: if (dv) begin
                m_entry.delete();
                m_entry.push_back(d);
                m_idle = 0;
                m_st = L_ENTRY;
            end
            L_ENTRY, L_PROG: begin
                if (cl) model_leave();
                else if (en && m_st == L_PROG) begin
                    if (m_entry.size() == ND) begin
                        for (int i = 0; i < ND; i++) m_code[i] = m_entry[i];
                        m_ok = 1'b1;
                    end else m_err = 1'b1;
                    m_entry.delete();
                    m_idle = 0;
                    m_st = L_UNL;
                end else if (en) begin
                    if (m_entry.size() == ND) m_st = L_CHECK;
                    else model_fail();
                end else if (dv && m_entry.size() < ND) begin
                    m_entry.push_back(d);
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (m_idle == ENT_TO) model_leave();
                end
            end
            L_CHECK: begin
                match = 1'b1;
                for (int i = 0; i < ND; i++) if (m_entry[i] != m_code[i]) match = 1'b0;
                if (match) begin
                    m_ok = 1'b1;
                    m_fail = 0;
                    m_entry.delete();
                    m_idle = 0;
                    m_st = L_UNL;
                end else model_fail();
            end
            L_LOCKOUT: begin
                m_left--;
                if (m_left == 0) begin
                    m_st = L_LOCKED;
                    m_fail = 0;
                end
            end
            L_UNL: begin
                if (en) m_st = L_LOCKED;
                else if (sc) begin
                    m_entry.delete();
                    m_idle = 0;
                    m_st = L_PROG;
                end else if (any_p) m_idle = 0;
                else begin
                    m_idle++;
                    if (m_idle == REL_C) m_st = L_LOCKED;
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [14:0] exp_vec();
        bit unl;
        unl = (m_st == L_UNL) || (m_st == L_PROG);
        return {!unl, unl, m_st == L_UNL, (m_st == L_LOCKOUT) || (m_st == L_PROG), m_st == L_LOCKOUT,
                m_ok, m_err, 4'(m_entry.size()), 4'(m_fail)};
    endfunction

    task automatic step(input bit dv, input int d, input bit en, input bit cl, input bit sc);
        digit_valid = dv;
        digit_in = 4'(d);
        enter_pulse = en;
        clear_pulse = cl;
        set_code_pulse = sc;
        @(posedge clk_in);
        model_step(dv, d, en, cl, sc);
        #1;
        digit_valid = 1'b0;
        enter_pulse = 1'b0;
        clear_pulse = 1'b0;
        set_code_pulse = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic digits(input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) step(1'b1, int'((v >> (4 * (n - 1 - i))) & 32'hF), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter_idle();
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        checks++; if ({locked, unlocked, enb_lock, disable_cnt, alarm, ok_pulse, err_pulse} !== 7'b1000000) $display("FAIL reset_status: got %b want 1000000", {locked, unlocked, enb_lock, disable_cnt, alarm, ok_pulse, err_pulse}); else passes++;
        checks++; if ({digit_idx, fail_cnt} !== 8'h00) $display("FAIL reset_counts: got %h want 00", {digit_idx, fail_cnt}); else passes++;
        rst = 1'b0;
        digits(1, 32'h7);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        digits(2, 32'h12);
        checks++; if ({digit_idx, fail_cnt} !== 8'h21) $display("FAIL pre_reset_counts: got %h want 21", {digit_idx, fail_cnt}); else passes++;
        #3 rst = 1'b1;
        model_reset();
        #1;
        checks++; if ({locked, enb_lock, digit_idx, fail_cnt} !== 10'b10_0000_0000) $display("FAIL async_reset: got %b want 1000000000", {locked, enb_lock, digit_idx, fail_cnt}); else passes++;
        @(posedge clk_in);
        #1 rst = 1'b0;
    endtask

    task automatic test_correct_code();
        digits(4, 32'h1234);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        checks++; if ({ok_pulse, locked} !== 2'b01) $display("FAIL check_cycle: got %b want 01", {ok_pulse, locked}); else passes++;
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        checks++; if ({ok_pulse, unlocked, enb_lock, fail_cnt} !== 7'b111_0000) $display("FAIL unlock: got %b want 1110000", {ok_pulse, unlocked, enb_lock, fail_cnt}); else passes++;
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        checks++; if (ok_pulse !== 1'b0) $display("FAIL ok_one_cycle: got %b want 0", ok_pulse); else passes++;
        idle(48);
        checks++; if (unlocked !== 1'b1) $display("FAIL relock_early: got unlocked=%b want 1", unlocked); else passes++;
        idle(1);
        checks++; if ({locked, enb_lock} !== 2'b10) $display("FAIL relock: got %b want 10", {locked, enb_lock}); else passes++;
    endtask

    task automatic test_three_fail();
        for (int k = 1; k <= 3; k++) begin
            digits(4, 32'h1235);
            enter_idle();
            checks++; if ({err_pulse, fail_cnt} !== {1'b1, 4'(k)}) $display("FAIL fail_%0d: got %b want %b", k, {err_pulse, fail_cnt}, {1'b1, 4'(k)}); else passes++;
        end
        checks++; if ({alarm, disable_cnt, locked} !== 3'b111) $display("FAIL lockout_enter: got %b want 111", {alarm, disable_cnt, locked}); else passes++;
        for (int i = 0; i < 19; i++) begin
            if (i < 15) step($urandom_range(1) == 1, int'($urandom_range(15)), $urandom_range(1) == 1, 1'b0, $urandom_range(3) == 0);
            else step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        end
        checks++; if ({alarm, digit_idx, fail_cnt} !== 9'b1_0000_0011) $display("FAIL lockout_hold: got %b want 100000011", {alarm, digit_idx, fail_cnt}); else passes++;
        idle(1);
        checks++; if ({alarm, disable_cnt, locked, fail_cnt} !== 7'b001_0000) $display("FAIL lockout_exit: got %b want 0010000", {alarm, disable_cnt, locked, fail_cnt}); else passes++;
    endtask

    task automatic test_boundary();
        digits(2, 32'h12);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        checks++; if ({err_pulse, fail_cnt, digit_idx} !== 9'b1_0001_0000) $display("FAIL short_enter: got %b want 100010000", {err_pulse, fail_cnt, digit_idx}); else passes++;
        digits(2, 32'h12);
        idle(29);
        checks++; if (digit_idx !== 4'd2) $display("FAIL entry_to_early: got %0d want 2", digit_idx); else passes++;
        idle(1);
        checks++; if ({locked, digit_idx, fail_cnt} !== 9'b1_0000_0001) $display("FAIL entry_to: got %b want 100000001", {locked, digit_idx, fail_cnt}); else passes++;
        digits(5, 32'h12349);
        checks++; if (digit_idx !== 4'd4) $display("FAIL digit_sat: got %0d want 4", digit_idx); else passes++;
        enter_idle();
        checks++; if ({ok_pulse, unlocked, fail_cnt} !== 6'b11_0000) $display("FAIL fifth_dropped: got %b want 110000", {ok_pulse, unlocked, fail_cnt}); else passes++;
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        checks++; if ({locked, enb_lock} !== 2'b10) $display("FAIL manual_lock: got %b want 10", {locked, enb_lock}); else passes++;
    endtask

    task automatic test_priority();
        digits(1, 32'h1);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        digits(4, 32'h1234);
        step(1'b0, 0, 1'b1, 1'b1, 1'b0);
        checks++; if ({locked, digit_idx, ok_pulse, err_pulse} !== 7'b1_0000_00) $display("FAIL clear_over_enter: got %b want 1000000", {locked, digit_idx, ok_pulse, err_pulse}); else passes++;
        idle(1);
        checks++; if ({unlocked, ok_pulse, err_pulse, fail_cnt} !== 7'b000_0001) $display("FAIL clear_no_pulse: got %b want 0000001", {unlocked, ok_pulse, err_pulse, fail_cnt}); else passes++;
    endtask

    task automatic test_reprogram();
        digits(4, 32'h1234);
        enter_idle();
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        checks++; if ({unlocked, enb_lock, disable_cnt, digit_idx} !== 7'b101_0000) $display("FAIL program_enter: got %b want 1010000", {unlocked, enb_lock, disable_cnt, digit_idx}); else passes++;
        digits(4, 32'h9876);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        checks++; if ({ok_pulse, enb_lock, disable_cnt} !== 3'b110) $display("FAIL program_store: got %b want 110", {ok_pulse, enb_lock, disable_cnt}); else passes++;
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        digits(4, 32'h1234);
        enter_idle();
        checks++; if ({err_pulse, locked} !== 2'b11) $display("FAIL old_code_rejected: got %b want 11", {err_pulse, locked}); else passes++;
        digits(4, 32'h9876);
        enter_idle();
        checks++; if ({ok_pulse, unlocked} !== 2'b11) $display("FAIL new_code_accepted: got %b want 11", {ok_pulse, unlocked}); else passes++;
        #3 rst = 1'b1;
        model_reset();
        @(posedge clk_in);
        #1 rst = 1'b0;
        digits(4, 32'h1234);
        enter_idle();
        checks++; if ({ok_pulse, unlocked} !== 2'b11) $display("FAIL reset_restores_code: got %b want 11", {ok_pulse, unlocked}); else passes++;
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int quiet;
        logic [14:0] got;
        quiet = 0;
        for (int i = 0; i < 5000; i++) begin
            bit dv, en, cl, sc;
            int d;
            dv = 1'b0; en = 1'b0; cl = 1'b0; sc = 1'b0; d = 0;
            if (quiet > 0) quiet--;
            else begin
                dv = $urandom_range(99) < 35;
                d = ($urandom_range(9) < 7 && m_entry.size() < ND) ? m_code[m_entry.size()] : int'($urandom_range(15));
                en = $urandom_range(99) < 6;
                cl = $urandom_range(99) < 2;
                sc = $urandom_range(99) < 6;
                if ($urandom_range(99) < 2) quiet = int'($urandom_range(60, 20));
            end
            step(dv, d, en, cl, sc);
            got = {locked, unlocked, enb_lock, disable_cnt, alarm, ok_pulse, err_pulse, digit_idx, fail_cnt};
            checks++; if (got !== exp_vec()) $display("FAIL random_cycle_%0d: got %b want %b", i, got, exp_vec()); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_correct_code();
        test_three_fail();
        test_boundary();
        test_priority();
        test_reprogram();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
